// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, load-use bubble,
// taken-branch flush and a saturating count of cycles in which the PC was held.
//
// state   | meaning
// S_RUN   | normal issue; a memory request launches the SRAM and freezes if MEM_WAIT>1
// S_ACCESS| SRAM access in flight; frozen until the release cycle cnt == MEM_WAIT-1
module pipeline_ctrl #(
  parameter int MEM_WAIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        stat_clr,
  output logic        pc_load,
  output logic        if_load,
  output logic        if_flush,
  output logic        id_load,
  output logic        id_flush,
  output logic        ex_load,
  output logic        mem_load,
  output logic        sram_start,
  output logic        mem_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic {S_RUN, S_ACCESS} state_t;

  localparam bit               FREEZE_EN = (MEM_WAIT > 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MEM_WAIT - 1);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_q, stall_d;
  logic             freeze, hold;

  always_comb begin
    freeze     = 1'b0;
    hold       = 1'b0;
    pc_load    = 1'b0;
    if_load    = 1'b0;
    if_flush   = 1'b0;
    id_load    = 1'b0;
    id_flush   = 1'b0;
    ex_load    = 1'b0;
    mem_load   = 1'b0;
    sram_start = 1'b0;
    mem_busy   = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (state_q == S_RUN) begin
      sram_start = mem_req;
      freeze     = mem_req && FREEZE_EN;
      if (freeze) begin
        state_d = S_ACCESS;
        cnt_d   = ONE_CNT;
      end
    end else begin
      hold = (cnt_q < LAST_CNT);
      if (hold) begin
        cnt_d = cnt_q + ONE_CNT;
      end else begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    end

    // Priority: freeze > branch > hazard > normal advance.
    if (freeze || hold) begin
      mem_busy = 1'b1;
    end else if (branch_taken) begin
      {pc_load, if_load, id_load, ex_load, mem_load} = 5'b11111;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (hazard) begin
      {id_load, ex_load, mem_load} = 3'b111;
      id_flush = 1'b1;
    end else begin
      {pc_load, if_load, id_load, ex_load, mem_load} = 5'b11111;
    end

    // Reset gates every control output straight away, including mid-access.
    if (rst) begin
      {pc_load, if_load, if_flush, id_load, id_flush} = 5'b0;
      {ex_load, mem_load, sram_start, mem_busy}       = 4'b0;
    end

    if (stat_clr)                              stall_d = '0;
    else if (!pc_load && stall_q != 16'hFFFF)  stall_d = stall_q + 16'd1;
    else                                       stall_d = stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a cycle-level occupancy model checked every
// negedge, plus literal expectations for each directed scenario.
module tb_pipeline_ctrl;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, stat_clr = 1'b0;
  logic        pc_load, if_load, if_flush, id_load, id_flush, ex_load, mem_load;
  logic        sram_start, mem_busy;
  logic [15:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  pipeline_ctrl #(.MEM_WAIT(MW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .stat_clr(stat_clr), .pc_load(pc_load), .if_load(if_load),
    .if_flush(if_flush), .id_load(id_load), .id_flush(id_flush), .ex_load(ex_load),
    .mem_load(mem_load), .sram_start(sram_start), .mem_busy(mem_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {pc, if, if_flush, id, id_flush, ex, mem, sram_start, mem_busy}
  function automatic logic [8:0] outs();
    return {pc_load, if_load, if_flush, id_load, id_flush, ex_load, mem_load,
            sram_start, mem_busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mem_left = cycles of the current MEM occupancy still to come after this one.
  int mem_left = 0;
  int m_stall  = 0;

  task automatic predict(output logic [8:0] e, output logic pc);
    logic start, frozen;
    start  = (mem_left == 0) && mem_req;
    frozen = start ? (MW > 1) : (mem_left > 1);
    if (frozen)            e = 9'b000000001;
    else if (branch_taken) e = 9'b111111100;
    else if (hazard)       e = 9'b000111100;
    else                   e = 9'b110101100;
    if (start) e[1] = 1'b1;
    if (rst)   e = 9'b0;
    pc = e[8];
  endtask

  always @(posedge clk or posedge rst) begin
    logic [8:0] e;
    logic pc;
    if (rst) begin
      mem_left = 0;
      m_stall  = 0;
    end else begin
      predict(e, pc);
      if (stat_clr)                  m_stall = 0;
      else if (!pc && m_stall < 65535) m_stall = m_stall + 1;
      if (mem_left == 0) mem_left = mem_req ? MW - 1 : 0;
      else               mem_left = mem_left - 1;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    logic pc;
    predict(e, pc);
    chk("model_outs", {23'd0, outs()}, {23'd0, e});
    chk("model_stall", {16'd0, stall_cycles}, m_stall);
  end

  task automatic drive(input logic h, input logic b, input logic m, input logic c);
    @(posedge clk);
    #1;
    hazard = h; branch_taken = b; mem_req = m; stat_clr = c;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_outs", {23'd0, outs()}, 32'd0);
    chk("reset_stall", {16'd0, stall_cycles}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    repeat (3) drive(0, 0, 0, 0);
    chk("idle_outs", {23'd0, outs()}, 32'h1AC);
    chk("idle_stall", {16'd0, stall_cycles}, 32'd0);

    drive(0, 0, 1, 0);
    chk("mem_start", {23'd0, outs()}, 32'h003);
    drive(0, 0, 0, 0);
    chk("mem_frz1", {23'd0, outs()}, 32'h001);
    drive(0, 0, 0, 0);
    chk("mem_frz2", {23'd0, outs()}, 32'h001);
    drive(0, 0, 0, 0);
    chk("mem_release", {23'd0, outs()}, 32'h1AC);
    drive(0, 0, 0, 0);
    chk("mem_stall", {16'd0, stall_cycles}, 32'd3);

    drive(1, 0, 0, 0);
    chk("hazard_outs", {23'd0, outs()}, 32'h03C);
    drive(0, 0, 0, 0);
    chk("hazard_stall", {16'd0, stall_cycles}, 32'd4);

    drive(1, 1, 0, 0);
    chk("branch_outs", {23'd0, outs()}, 32'h1FC);
    drive(0, 0, 0, 0);
    chk("branch_stall", {16'd0, stall_cycles}, 32'd4);

    drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    chk("acc_branch1", {23'd0, outs()}, 32'h001);
    drive(0, 1, 0, 0);
    chk("acc_branch2", {23'd0, outs()}, 32'h001);
    drive(0, 1, 0, 0);
    chk("acc_release_br", {23'd0, outs()}, 32'h1FC);
    drive(0, 0, 0, 0);
    chk("acc_stall", {16'd0, stall_cycles}, 32'd7);

    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outs", {23'd0, outs()}, 32'd0);
    chk("rst_mid_stall", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    drive(0, 0, 0, 0);
    chk("post_rst_run", {23'd0, outs()}, 32'h1AC);
    drive(0, 0, 0, 0);
    chk("post_rst_idle", {23'd0, outs()}, 32'h1AC);

    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    chk("sat_start", {16'd0, stall_cycles}, 32'd0);
    repeat (65534) @(negedge clk);
    chk("sat_fffe", {16'd0, stall_cycles}, 32'hFFFE);
    repeat (3) @(negedge clk);
    chk("sat_ffff", {16'd0, stall_cycles}, 32'hFFFF);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 0);
    chk("clr_priority", {16'd0, stall_cycles}, 32'd0);
    drive(0, 0, 0, 0);
    chk("clr_then_inc", {16'd0, stall_cycles}, 32'd1);

    drive(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
